// File: rtl/adder_pkg.sv
// Shared definitions for the adder operand sequencer: adder width and the
// sequencer state encoding.
package adder_pkg;

    localparam int ADD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that measures the adder settle window. Loaded on accept,
// counts down while running, and reports expiry when it reaches zero.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(SETTLE_CYCLES - 1);
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/adder_operand_sequencer.sv
// Wraps the combinational ripple-carry adder: accepts one operand set, holds it
// on the adder inputs for a settle window, then registers and presents the result.
module adder_operand_sequencer
    import adder_pkg::*;
#(
    parameter int WIDTH         = ADD_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_c,
    input  logic [WIDTH:0]   add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    state_t state;
    state_t state_next;
    logic   accept;
    logic   capture;
    logic   expired;

    // Handshakes: a transfer happens on an edge where valid and ready are both high;
    // in_ready and out_valid are pure decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign capture   = (state == SETTLE) && expired;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .run    (state == SETTLE),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SETTLE;
            SETTLE:  if (expired)   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a <= '0;
            add_b <= '0;
            add_c <= 1'b0;
        end else if (accept) begin
            add_a <= a;
            add_b <= b;
            add_c <= cin;
        end
    end

    // Overflow is judged from the held operands, which are still on the adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (capture) begin
            sum  <= add_s[WIDTH-1:0];
            cout <= add_s[WIDTH];
            zero <= (add_s[WIDTH-1:0] == '0);
            ovf  <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                    (add_s[WIDTH-1] != add_a[WIDTH-1]);
        end
    end

endmodule
